// File: rtl/io_fabric.sv
// Memory-mapped I/O fabric: mask-decoded peripheral slots with per-slot wait states,
// a registered read-data mux and a control/status window (slot enables, sticky bus error).
module io_fabric #(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  // Slot 0 sits in the LSBs, so these lists read slot 3 first.
  parameter logic [NUM_SLOTS*ADDR_WIDTH-1:0] SLOT_BASE = {16'hD010, 16'hD000, 16'h0000, 16'hE000},
  parameter logic [NUM_SLOTS*ADDR_WIDTH-1:0] SLOT_MASK = {16'hFFFE, 16'hFFF8, 16'hE000, 16'hE000},
  parameter logic [NUM_SLOTS*4-1:0]          SLOT_WAIT = {4'd1, 4'd2, 4'd0, 4'd0},
  parameter logic [ADDR_WIDTH-1:0]           CTRL_ADDR = 16'hD0F0,
  parameter logic [7:0]                      OPEN_BUS  = 8'hA5
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [ADDR_WIDTH-1:0]           A,
  input  logic [DATA_WIDTH-1:0]           DI,
  input  logic                            R_W_n,
  input  logic                            VALID,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] SLOT_DO,
  output logic [NUM_SLOTS-1:0]            SEL,
  output logic                            WR_STB,
  output logic [DATA_WIDTH-1:0]           DO,
  output logic                            RDY,
  output logic                            BUS_ERR
);

  localparam int EW = (ADDR_WIDTH < 16) ? ADDR_WIDTH : 16;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    accept, done;

  logic                    ctrl_hit, found;
  logic [NUM_SLOTS-1:0]    dec_sel;
  logic [3:0]              dec_wait;

  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [NUM_SLOTS-1:0]    lat_wdata;
  logic                    lat_read;
  logic                    lat_ctrl;

  logic [NUM_SLOTS-1:0]    enable;
  logic [ADDR_WIDTH-1:0]   err_addr;
  logic [15:0]             err_ext;
  logic [DATA_WIDTH-1:0]   ctrl_rd, slot_rd;
  logic                    unused_di;

  assign unused_di = ^DI;
  assign ctrl_hit  = (A[ADDR_WIDTH-1:2] == CTRL_ADDR[ADDR_WIDTH-1:2]);
  assign err_ext   = 16'(err_addr[EW-1:0]);

  // Lowest-index enabled slot wins; the control window shadows every slot.
  always_comb begin
    dec_sel  = '0;
    dec_wait = '0;
    found    = 1'b0;
    if (!ctrl_hit) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!found && enable[i] &&
            ((A & SLOT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLOT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          found      = 1'b1;
          dec_sel[i] = 1'b1;
          dec_wait   = SLOT_WAIT[i*4 +: 4];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The completion cycle also samples VALID so requests can run back-to-back.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (VALID) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = dec_wait;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          done = 1'b1;
          if (VALID) begin
            accept   = 1'b1;
            cnt_next = dec_wait;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign RDY    = done;
  assign WR_STB = done && !lat_read && (SEL != '0);

  always_comb begin
    slot_rd = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SEL[i]) slot_rd = slot_rd | SLOT_DO[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ctrl_rd = '0;
    case (lat_addr[1:0])
      2'd0:    ctrl_rd[NUM_SLOTS-1:0] = enable;
      2'd1:    ctrl_rd[0] = BUS_ERR;
      2'd2:    ctrl_rd[7:0] = err_ext[7:0];
      default: ctrl_rd[7:0] = err_ext[15:8];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEL       <= '0;
      DO        <= '0;
      BUS_ERR   <= 1'b0;
      err_addr  <= '0;
      enable    <= '1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_read  <= 1'b0;
      lat_ctrl  <= 1'b0;
    end else begin
      if (accept) begin
        SEL       <= dec_sel;
        lat_addr  <= A;
        lat_wdata <= DI[NUM_SLOTS-1:0];
        lat_read  <= R_W_n;
        lat_ctrl  <= ctrl_hit;
      end else if (done) begin
        SEL <= '0;
      end
      if (done) begin
        if (lat_ctrl) begin
          if (lat_read) begin
            DO <= ctrl_rd;
          end else begin
            case (lat_addr[1:0])
              2'd0: enable <= lat_wdata;
              2'd1: begin
                if (lat_wdata[0]) begin
                  BUS_ERR  <= 1'b0;
                  err_addr <= '0;
                end
              end
              default: ;
            endcase
          end
        end else if (SEL != '0) begin
          if (lat_read) DO <= slot_rd;
        end else begin
          // Unmapped: first error address is kept until software clears it.
          if (lat_read) DO <= DATA_WIDTH'(OPEN_BUS);
          if (!BUS_ERR) begin
            BUS_ERR  <= 1'b1;
            err_addr <= lat_addr;
          end
        end
      end
    end
  end

endmodule
